// File: rtl/sam_config_loader.sv
// Serial configuration loader for the SAM engine: deserialises n, d and capsN
// from a bit stream and commits them atomically to the datapath outputs.
module sam_config_loader #(
    parameter int MAX_LOG = 4,
    parameter int KW      = 2 ** MAX_LOG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            str,
    output logic [3:0]      cfg_n,
    output logic [KW-1:0]   cfg_d,
    output logic [KW-1:0]   cfg_capsn,
    output logic            cfg_valid,
    output logic            cfg_done,
    output logic            cfg_err,
    output logic            busy
);

    localparam int         CW    = MAX_LOG + 1;
    localparam logic [3:0] MAX_N = 4'(MAX_LOG);

    typedef enum logic [2:0] {
        IDLE, SYNC, LOAD_N, LOAD_D, LOAD_C, HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      n_sh_q, n_sh_d;
    logic [KW-1:0]   d_sh_q, d_sh_d;
    logic [KW-1:0]   c_sh_q, c_sh_d;
    logic [3:0]      cfg_n_q, cfg_n_d;
    logic [KW-1:0]   cfg_d_q, cfg_d_d;
    logic [KW-1:0]   cfg_c_q, cfg_c_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    // Set once mode has been seen low, so a load held through reset cannot restart
    logic            armed_q, armed_d;

    logic [3:0]      n_next;
    logic [KW-1:0]   d_next;
    logic [KW-1:0]   c_next;
    logic            last_bit;

    assign n_next   = (n_sh_q << 1) | {3'b000, str};
    assign d_next   = (d_sh_q << 1) | KW'(str);
    assign c_next   = (c_sh_q << 1) | KW'(str);
    assign last_bit = (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_sh_d  = n_sh_q;
        d_sh_d  = d_sh_q;
        c_sh_d  = c_sh_q;
        cfg_n_d = cfg_n_q;
        cfg_d_d = cfg_d_q;
        cfg_c_d = cfg_c_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        armed_d = armed_q | ~mode;

        unique case (state_q)
            IDLE: begin
                if (mode && armed_q) state_d = SYNC;
            end
            SYNC: begin
                if (!mode) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    n_sh_d  = {3'b000, str};
                    cnt_d   = CW'(3);
                    state_d = LOAD_N;
                end
            end
            LOAD_N: begin
                if (!mode) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    n_sh_d = n_next;
                    if (!last_bit) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (n_next > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = CW'(1) << n_next;
                        d_sh_d  = '0;
                        state_d = LOAD_D;
                    end
                end
            end
            LOAD_D: begin
                if (!mode) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    d_sh_d = d_next;
                    if (!last_bit) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        cnt_d   = CW'(1) << n_sh_q;
                        c_sh_d  = '0;
                        state_d = LOAD_C;
                    end
                end
            end
            LOAD_C: begin
                if (!mode) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    c_sh_d = c_next;
                    if (!last_bit) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        cfg_n_d = n_sh_q;
                        cfg_d_d = d_sh_q;
                        cfg_c_d = c_next;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!mode) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_sh_q  <= '0;
            d_sh_q  <= '0;
            c_sh_q  <= '0;
            cfg_n_q <= '0;
            cfg_d_q <= '0;
            cfg_c_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= ~mode;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_sh_q  <= n_sh_d;
            d_sh_q  <= d_sh_d;
            c_sh_q  <= c_sh_d;
            cfg_n_q <= cfg_n_d;
            cfg_d_q <= cfg_d_d;
            cfg_c_q <= cfg_c_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign cfg_n     = cfg_n_q;
    assign cfg_d     = cfg_d_q;
    assign cfg_capsn = cfg_c_q;
    assign cfg_valid = valid_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign busy      = (state_q == SYNC) || (state_q == LOAD_N) ||
                       (state_q == LOAD_D) || (state_q == LOAD_C);

endmodule

// File: tb/tb_sam_config_loader.sv
// Scoreboard bench for sam_config_loader: the driver queues expected
// commit/error pulses, a negedge monitor pops and compares them.
module tb_sam_config_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        str = 1'b0;
    logic [3:0]  cfg_n;
    logic [15:0] cfg_d;
    logic [15:0] cfg_capsn;
    logic        cfg_valid;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;

    sam_config_loader #(.MAX_LOG(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .str(str),
        .cfg_n(cfg_n), .cfg_d(cfg_d), .cfg_capsn(cfg_capsn),
        .cfg_valid(cfg_valid), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          at;
        logic [3:0]  n;
        logic [15:0] d;
        logic [15:0] c;
        logic        v;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int passed = 0;

    // reference of the committed configuration
    logic [3:0]  m_n = '0;
    logic [15:0] m_d = '0;
    logic [15:0] m_c = '0;
    logic        m_v = 1'b0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset && cfg_done && cfg_err) check("done_err_both", 1, 0);
        if (!reset && (cfg_done || cfg_err)) begin
            if (sbq.size() == 0) begin
                check("unexpected_pulse", {cfg_done, cfg_err}, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("pulse_kind", {cfg_done, cfg_err},
                      e.is_err ? 2'b01 : 2'b10);
                check("pulse_cycle", cyc, e.at);
                check("cfg_n", cfg_n, e.n);
                check("cfg_d", cfg_d, e.d);
                check("cfg_capsn", cfg_capsn, e.c);
                check("cfg_valid", cfg_valid, e.v);
            end
        end
    end

    task automatic run_load(input logic [3:0] n, input logic [15:0] d,
                            input logic [15:0] c, input int abort_at,
                            input int rst_at, input int hold_extra);
        bit   bits[$];
        bit   legal;
        int   k;
        int   last;
        int   e0;
        exp_t e;
        legal = (n <= 4);
        k = legal ? (1 << n) : 8;
        last = 4 + 2 * k;
        for (int b = 3; b >= 0; b--) bits.push_back(n[b]);
        for (int b = k - 1; b >= 0; b--) bits.push_back(legal ? d[b] : 1'b1);
        for (int b = k - 1; b >= 0; b--) bits.push_back(legal ? c[b] : 1'b0);
        @(negedge clk);
        e0 = cyc + 1;
        if (rst_at < 0) begin
            e.is_err = (abort_at >= 0) || !legal;
            e.at = (abort_at >= 0) ? e0 + abort_at
                 : (!legal ? e0 + 4 : e0 + last);
            if (!e.is_err) begin
                m_n = n;
                m_d = d;
                m_c = c;
                m_v = 1'b1;
            end
            e.n = m_n;
            e.d = m_d;
            e.c = m_c;
            e.v = m_v;
            sbq.push_back(e);
        end
        for (int i = 0; i <= last + hold_extra; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1 && abort_at != 1 && rst_at != 1)
                check("busy_sync", busy, 1);
            if (i == last && legal && abort_at < 0 && rst_at < 0)
                check("busy_last", busy, 1);
            mode  = (i != abort_at);
            reset = (i == rst_at);
            if (i >= 1 && i - 1 < bits.size()) str = bits[i - 1];
            else str = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (i == abort_at || i == rst_at) break;
        end
        @(negedge clk);
        reset = 1'b0;
        if (rst_at < 0) begin
            check("busy_after", busy, 0);
            mode = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_n", cfg_n, 0);
        check("rst_d", cfg_d, 0);
        check("rst_c", cfg_capsn, 0);
        check("rst_valid", cfg_valid, 0);
        check("rst_pulses", {cfg_done, cfg_err}, 0);
        check("rst_busy", busy, 0);

        repeat ($urandom_range(0, 15)) @(negedge clk);
        run_load(4'd3, 16'h00A5, 16'h003C, -1, -1, 5);
        check("nom_d", cfg_d, 16'h00A5);
        check("nom_c", cfg_capsn, 16'h003C);

        run_load(4'd3, 16'h00FF, 16'h0011, 10, -1, 0);
        check("abort_keep_d", cfg_d, 16'h00A5);
        check("abort_valid", cfg_valid, 1);

        run_load(4'd5, 16'h0000, 16'h0000, -1, -1, 0);
        check("illegal_keep_n", cfg_n, 3);

        run_load(4'd0, 16'h0001, 16'h0001, -1, -1, 0);
        run_load(4'd4, 16'hBEEF, 16'h1234, -1, -1, 0);
        run_load(4'd1, 16'h0002, 16'h0003, -1, -1, 0);
        check("zero_fill_d", cfg_d, 16'h0002);

        run_load(4'd3, 16'h0055, 16'h00AA, -1, 8, 0);
        m_n = '0;
        m_d = '0;
        m_c = '0;
        m_v = 1'b0;
        check("mid_rst_n", cfg_n, 0);
        check("mid_rst_d", cfg_d, 0);
        check("mid_rst_c", cfg_capsn, 0);
        check("mid_rst_valid", cfg_valid, 0);
        check("mid_rst_busy", busy, 0);
        repeat (4) begin
            @(negedge clk);
            check("no_restart_busy", busy, 0);
        end
        mode = 1'b0;
        repeat (2) @(negedge clk);
        run_load(4'd2, 16'h0009, 16'h0006, -1, -1, 0);
        check("post_rst_n", cfg_n, 2);

        for (int t = 0; t < 50 && sbq.size() != 0; t++) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
